fb_frame_reorder: RTL and testbench

FB_FRAME_REORDER -- requirements
Module: fb_frame_reorder

---
 rtl/fb_frame_reorder_pkg.sv | 30 +++
 rtl/fb_frame_reorder_dpram.sv | 25 ++
 rtl/fb_frame_reorder.sv | 161 ++++++++++++++++
 tb/tb_fb_frame_reorder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_frame_reorder_pkg.sv
// Shared filterbank package: write/read state encodings and the bit-reverse helper
// used by the frame reorder buffer.
package fb_frame_reorder_pkg;

  typedef enum logic {
    WR_SYNC = 1'b0,
    WR_FILL = 1'b1
  } wr_state_e;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_e;

  // Reverses the low nbits of val; bits above nbits come back as zero.
  function automatic logic [31:0] bitrev(input int nbits, input logic [31:0] val);
    logic [31:0] r;
    logic [31:0] v;
    r = '0;
    v = val;
    for (int b = 0; b < 32; b++) begin
      if (b < nbits) begin
        r = {r[30:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fb_frame_reorder_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on contents.
module fb_dpram #(
  parameter int AW = 4,
  parameter int DW = 33
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/fb_frame_reorder.sv
// Ping-pong frame buffer that realigns filterbank output into whole frames and drains
// them in natural order, or bit-reversed order when FB_REORDER_BITREV_EN is defined.
module fb_frame_reorder
  import fb_frame_reorder_pkg::*;
#(
  parameter int N      = 8,
  parameter int LOG_N  = 3,
  parameter int WIDTH  = 32,
  parameter int MWIDTH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_nd,
  input  logic [MWIDTH-1:0] in_m,
  input  logic              in_first,
  input  logic              in_error,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_nd,
  output logic [MWIDTH-1:0] out_m,
  output logic              out_first,
  output logic              error
);

  localparam int DW = WIDTH + MWIDTH;
  localparam int AW = LOG_N + 1;

  wr_state_e        wr_state_q;
  logic             wr_bank_q;
  logic [LOG_N-1:0] wr_idx_q;
  rd_state_e        rd_state_q;
  logic             rd_bank_q;
  logic [LOG_N-1:0] rd_step_q;
  logic             ram_vld_q;
  logic             ram_first_q;

  logic             ram_we;
  logic [LOG_N-1:0] w_idx;
  logic             realign;
  logic             frame_done;
  logic [LOG_N-1:0] rd_idx;
  logic             rd_active;
  logic             rd_last;
  logic [DW-1:0]    ram_rdata;

  always_comb begin
    ram_we     = 1'b0;
    w_idx      = '0;
    realign    = 1'b0;
    frame_done = 1'b0;
    if (in_nd) begin
      if (wr_state_q == WR_SYNC) begin
        ram_we = in_first;
      end else begin
        ram_we = 1'b1;
        if (in_first && (wr_idx_q != '0)) begin
          realign = 1'b1;
        end else begin
          w_idx      = wr_idx_q;
          frame_done = (wr_idx_q == LOG_N'(N - 1));
        end
      end
    end
  end

  assign rd_active = (rd_state_q == RD_DRAIN);
  assign rd_last   = rd_active && (rd_step_q == LOG_N'(N - 1));

`ifdef FB_REORDER_BITREV_EN
  assign rd_idx = LOG_N'(bitrev(LOG_N, 32'(rd_step_q)));
`else
  assign rd_idx = rd_step_q;
`endif

  fb_dpram #(.AW(AW), .DW(DW)) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i ({wr_bank_q, w_idx}),
    .wdata_i ({in_data, in_m}),
    .re_i    (rd_active),
    .raddr_i ({rd_bank_q, rd_idx}),
    .rdata_o (ram_rdata)
  );

  // A realigning in_first restarts the current bank at index 0 instead of swapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= WR_SYNC;
      wr_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
    end else if (in_nd) begin
      case (wr_state_q)
        WR_SYNC: begin
          if (in_first) begin
            wr_state_q <= WR_FILL;
            wr_idx_q   <= LOG_N'(1);
          end
        end
        default: begin
          if (realign) begin
            wr_idx_q <= LOG_N'(1);
          end else if (frame_done) begin
            wr_idx_q  <= '0;
            wr_bank_q <= ~wr_bank_q;
          end else begin
            wr_idx_q <= wr_idx_q + LOG_N'(1);
          end
        end
      endcase
    end
  end

  // Frames take at least N cycles to fill, so a new request can only coincide with
  // the final drain step; it is chained straight into the next drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q  <= RD_IDLE;
      rd_bank_q   <= 1'b0;
      rd_step_q   <= '0;
      ram_vld_q   <= 1'b0;
      ram_first_q <= 1'b0;
    end else begin
      ram_vld_q   <= rd_active;
      ram_first_q <= rd_active && (rd_step_q == '0);
      case (rd_state_q)
        RD_IDLE: begin
          if (frame_done) begin
            rd_state_q <= RD_DRAIN;
            rd_step_q  <= '0;
            rd_bank_q  <= wr_bank_q;
          end
        end
        default: begin
          if (rd_last) begin
            rd_step_q <= '0;
            if (frame_done) rd_bank_q <= wr_bank_q;
            else            rd_state_q <= RD_IDLE;
          end else begin
            rd_step_q <= rd_step_q + LOG_N'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_nd    <= 1'b0;
      out_first <= 1'b0;
      out_data  <= '0;
      out_m     <= '0;
      error     <= 1'b0;
    end else begin
      out_nd    <= ram_vld_q;
      out_first <= ram_vld_q && ram_first_q;
      if (ram_vld_q) {out_data, out_m} <= ram_rdata;
      error     <= error | in_error | realign;
    end
  end

endmodule

// File: tb/tb_fb_frame_reorder.sv
// Scoreboard bench for fb_frame_reorder: queue-based frame model feeds an expected queue
// that a negedge monitor drains; honours FB_REORDER_BITREV_EN for the output order.
module tb_fb_frame_reorder;

  localparam int N = 8;
  localparam int LOG_N = 3;

  typedef struct {
    logic [31:0] d;
    logic        m;
  } samp_t;

  typedef struct {
    logic [31:0] d;
    logic        m;
    logic        first;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_nd = 1'b0;
  logic        in_m = 1'b0;
  logic        in_first = 1'b0;
  logic        in_error = 1'b0;
  logic [31:0] out_data;
  logic        out_nd;
  logic        out_m;
  logic        out_first;
  logic        error;

  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    out_count = 0;
  exp_t  exp_q[$];
  samp_t frame_q[$];
  bit    synced = 1'b0;
  bit    err_exp = 1'b0;
  logic [31:0] last_d = '0;
  logic        last_m = 1'b0;

  fb_frame_reorder #(.N(N), .LOG_N(LOG_N), .WIDTH(32), .MWIDTH(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_nd(in_nd), .in_m(in_m),
    .in_first(in_first), .in_error(in_error), .out_data(out_data), .out_nd(out_nd),
    .out_m(out_m), .out_first(out_first), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int out_order(input int i);
    int r;
    r = i;
`ifdef FB_REORDER_BITREV_EN
    r = 0;
    for (int b = 0; b < LOG_N; b++) r = r * 2 + ((i >> b) & 1);
`endif
    return r;
  endfunction

  // Frame model: collect aligned samples; a premature in_first restarts the frame.
  function automatic void model_sample(input logic first, input logic [31:0] d,
                                       input logic m, input int k);
    samp_t s;
    s.d = d;
    s.m = m;
    if (!synced) begin
      if (first) begin
        synced = 1'b1;
        frame_q.delete();
        frame_q.push_back(s);
      end
    end else if (first && frame_q.size() != 0) begin
      err_exp = 1'b1;
      frame_q.delete();
      frame_q.push_back(s);
    end else begin
      frame_q.push_back(s);
    end
    if (synced && frame_q.size() == N) begin
      for (int i = 0; i < N; i++) begin
        exp_t e;
        e.d = frame_q[out_order(i)].d;
        e.m = frame_q[out_order(i)].m;
        e.first = (i == 0);
        e.cyc = k + 2 + i;
        exp_q.push_back(e);
      end
      frame_q.delete();
    end
  endfunction

  task automatic model_reset();
    exp_q.delete();
    frame_q.delete();
    synced = 1'b0;
    err_exp = 1'b0;
  endtask

  task automatic drive(input logic nd, input logic first, input logic [31:0] d, input logic m);
    @(posedge clk);
    #1;
    in_nd = nd;
    in_first = first;
    in_data = d;
    in_m = m;
    if (nd) model_sample(first, d, m, cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
  endtask

  task automatic send_frame(input bit with_first, input int gap_max);
    for (int i = 0; i < N; i++) begin
      drive(1'b1, with_first && (i == 0), $urandom, 1'($urandom_range(0, 1)));
      if (gap_max > 0) idle($urandom_range(0, gap_max));
    end
  endtask

  task automatic wait_empty(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last_d = '0;
      last_m = 1'b0;
    end else if (out_nd) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_nd", 64'(out_nd), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", 64'(out_data), 64'(e.d));
        chk("out_m", 64'(out_m), 64'(e.m));
        chk("out_first", 64'(out_first), 64'(e.first));
        chk("out_cycle", 64'(cyc), 64'(e.cyc));
      end
      last_d = out_data;
      last_m = out_m;
      out_count++;
    end else begin
      chk("idle_out_first", 64'(out_first), 64'd0);
      chk("idle_hold_data", 64'(out_data), 64'(last_d));
      chk("idle_hold_m", 64'(out_m), 64'(last_m));
    end
  end

  initial begin
    int base;
    int t;
    #12;
    chk("rst_out_nd", 64'(out_nd), 64'd0);
    chk("rst_out_first", 64'(out_first), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_m", 64'(out_m), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Unaligned samples are dropped, then the counting frame 0..7.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 32'(100 + i), 1'b1);
    for (int i = 0; i < N; i++) drive(1'b1, i == 0, 32'(i), 1'(i));
    idle(1);
    wait_empty("drain_count_frame");
    chk("error_after_sync_drop", 64'(error), 64'(err_exp));

    for (int f = 0; f < 4; f++) begin
      send_frame(1'b1, 2);
      idle($urandom_range(0, 12));
    end
    idle(1);
    wait_empty("drain_gapped_frames");

    // Three back-to-back frames; later ones rely on the index wrap, not in_first.
    for (int f = 0; f < 3; f++) send_frame(f == 0, 0);
    idle(1);
    wait_empty("drain_back_to_back");
    chk("error_clean_run", 64'(error), 64'd0);

    for (int i = 0; i < 5; i++) drive(1'b1, i == 0, $urandom, 1'b0);
    send_frame(1'b1, 0);
    idle(1);
    wait_empty("drain_after_realign");
    chk("error_realign", 64'(error), 64'(err_exp));
    idle(10);
    chk("error_sticky", 64'(error), 64'd1);

    base = out_count;
    send_frame(1'b1, 0);
    idle(1);
    t = 0;
    while (out_count - base < 3 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("reach_third_output", 64'(out_count - base >= 3), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_out_nd", 64'(out_nd), 64'd0);
    chk("midrst_error", 64'(error), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(15);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, $urandom, 1'b1);
    send_frame(1'b1, 1);
    idle(1);
    wait_empty("drain_after_reset");
    chk("error_after_reset", 64'(error), 64'd0);

    @(posedge clk);
    #1;
    in_error = 1'b1;
    err_exp = 1'b1;
    @(posedge clk);
    #1;
    in_error = 1'b0;
    idle(3);
    chk("error_in_error", 64'(error), 64'(err_exp));

    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
